proc_mem: RTL and testbench

PROC_MEM -- requirements
Module: proc_mem

---
 rtl/proc_mem_pkg.sv | 10 +
 rtl/proc_mem_fifo.sv | 41 ++++
 rtl/proc_mem.sv | 76 +++++++
 tb/tb_proc_mem.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/proc_mem_pkg.sv
// proc_mem_pkg: shared TinyRV1 memory-map constants and request encodings
package proc_mem_pkg;
  localparam logic [31:0] MMIO_OUT  = 32'h0000_2000;
  localparam logic [31:0] MMIO_IN   = 32'h0000_2004;
  localparam logic [31:0] MMIO_STAT = 32'h0000_2008;
  typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_e;
  function automatic logic is_mmio(input logic [31:0] a);
    return a == MMIO_OUT || a == MMIO_IN || a == MMIO_STAT;
  endfunction
endpackage

// File: rtl/proc_mem_fifo.sv
// FifoQueue: DEPTH-entry (power of two) FIFO with show-ahead head
//   push/din enqueue (accepted when not full, or full while popping)
//   pop dequeues when non-empty; head/full/empty report state
module FifoQueue #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (AW+1)'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    head = mem_q[rd_q];
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/proc_mem.sv
// proc_mem: TinyRV1 test memory -- word RAM with imem/dmem ports, bench preload and MMIO queues
//   imemreq_*/imemresp_data : combinational fetch port
//   dmemreq_*/dmemresp_rdata: combinational read, write commits at clock edge
//   ld_*                    : bench preload write port (wins over dmem writes)
//   out_* / in_*            : valid/ready queues to/from the bench via MMIO
//   err                     : sticky bad-address / queue over/underflow flag
module proc_mem import proc_mem_pkg::*; #(
  parameter int WORDS = 256,
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        out_val,
  output logic [31:0] out_data,
  input  logic        out_rdy,
  input  logic        in_val,
  input  logic [31:0] in_data,
  output logic        in_rdy,
  output logic        err
);
  localparam int WA = $clog2(WORDS);
  logic [31:0] ram_q [WORDS];
  logic [31:0] in_head;
  logic i_ram, i_bad, d_ram, d_wr, d_out, d_in, d_st, d_bad, ld_ok;
  logic out_push, out_pop, out_full, out_empty, in_push, in_pop, in_full, in_empty;
  logic err_q, err_d;
  always_comb begin
    i_ram = imemreq_addr[31:WA+2] == '0 && imemreq_addr[1:0] == 2'b0;
    i_bad = imemreq_val && !i_ram && !is_mmio(imemreq_addr);
    d_ram = dmemreq_addr[31:WA+2] == '0 && dmemreq_addr[1:0] == 2'b0;
    d_wr = dmemreq_type == REQ_WRITE;
    d_out = dmemreq_val && d_wr && dmemreq_addr == MMIO_OUT;
    d_in = dmemreq_val && !d_wr && dmemreq_addr == MMIO_IN;
    d_st = dmemreq_val && !d_wr && dmemreq_addr == MMIO_STAT;
    d_bad = dmemreq_val && !d_ram && !d_out && !d_in && !d_st;
    ld_ok = ld_en && ld_addr[31:WA+2] == '0 && ld_addr[1:0] == 2'b0;
    imemresp_data = imemreq_val && i_ram ? ram_q[imemreq_addr[WA+1:2]] : '0;
    dmemresp_rdata = dmemreq_val && !d_wr && d_ram ? ram_q[dmemreq_addr[WA+1:2]] :
                     d_in ? (in_empty ? '0 : in_head) :
                     d_st ? {30'b0, !in_empty, !out_full} : '0;
    out_val = !out_empty;
    out_pop = out_val && out_rdy;
    out_push = d_out && !rst;
    in_rdy = !in_full;
    in_push = in_val && in_rdy;
    in_pop = d_in && !in_empty && !rst;
    err_d = err_q | i_bad | d_bad | (d_out && out_full && !out_pop) | (d_in && in_empty);
    err = err_q;
  end
  // preload is the later assignment so it overrides a same-word dmem write
  always_ff @(posedge clk) begin
    if (!rst && dmemreq_val && d_wr && d_ram) ram_q[dmemreq_addr[WA+1:2]] <= dmemreq_wdata;
    if (ld_ok) ram_q[ld_addr[WA+1:2]] <= ld_wdata;
  end
  always_ff @(posedge clk)
    err_q <= rst ? 1'b0 : err_d;
  FifoQueue #(.DEPTH(QDEPTH), .W(32)) u_outq (
    .clk(clk), .rst(rst), .push(out_push), .din(dmemreq_wdata), .pop(out_pop),
    .head(out_data), .full(out_full), .empty(out_empty)
  );
  FifoQueue #(.DEPTH(QDEPTH), .W(32)) u_inq (
    .clk(clk), .rst(rst), .push(in_push), .din(in_data), .pop(in_pop),
    .head(in_head), .full(in_full), .empty(in_empty)
  );
endmodule

// File: tb/tb_proc_mem.sv
// tb_proc_mem: directed self-checking bench for proc_mem
module tb_proc_mem;
  logic clk = 1'b0;
  logic rst;
  logic imemreq_val, dmemreq_val, dmemreq_type, ld_en, out_rdy, in_val;
  logic [31:0] imemreq_addr, dmemreq_addr, dmemreq_wdata, ld_addr, ld_wdata, in_data;
  logic [31:0] imemresp_data, dmemresp_rdata, out_data;
  logic out_val, in_rdy, err;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  proc_mem dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .out_val(out_val), .out_data(out_data), .out_rdy(out_rdy),
    .in_val(in_val), .in_data(in_data), .in_rdy(in_rdy), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    imemreq_val = 0; imemreq_addr = 0;
    dmemreq_val = 0; dmemreq_type = 0; dmemreq_addr = 0; dmemreq_wdata = 0;
    ld_en = 0; ld_addr = 0; ld_wdata = 0; in_val = 0; in_data = 0;
  endtask
  task automatic dreq(input logic t, input logic [31:0] a, input logic [31:0] d);
    dmemreq_val = 1; dmemreq_type = t; dmemreq_addr = a; dmemreq_wdata = d;
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask
  initial begin
    idle();
    out_rdy = 0;
    do_reset();
    #1;
    chk("rst_out_val", 32'(out_val), 0);
    chk("rst_in_rdy", 32'(in_rdy), 1);
    chk("rst_err", 32'(err), 0);
    ld_en = 1; ld_addr = 32'h10; ld_wdata = 32'h1111_1111;
    step();
    ld_addr = 32'h20; ld_wdata = 32'h0;
    step();
    ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF;
    imemreq_val = 1; imemreq_addr = 32'h10;
    #1 chk("preload_old", imemresp_data, 32'h1111_1111);
    step();
    ld_en = 0;
    #1 chk("preload_new", imemresp_data, 32'hDEAD_BEEF);
    imemreq_addr = 32'h20;
    dreq(1, 32'h20, 32'h1234_5678);
    #1 chk("wr_same_cycle_imem", imemresp_data, 0);
    chk("wr_no_rdata", dmemresp_rdata, 0);
    step();
    dreq(0, 32'h20, 0);
    #1 chk("rd_after_wr", dmemresp_rdata, 32'h1234_5678);
    chk("rd_imem_after_wr", imemresp_data, 32'h1234_5678);
    chk("wr_err", 32'(err), 0);
    dreq(1, 32'h24, 32'hBBBB_BBBB);
    ld_en = 1; ld_addr = 32'h24; ld_wdata = 32'hAAAA_AAAA;
    step();
    ld_en = 0;
    dreq(0, 32'h24, 0);
    #1 chk("ld_wins", dmemresp_rdata, 32'hAAAA_AAAA);
    step();
    chk("ld_wins_err", 32'(err), 0);
    for (int i = 1; i <= 5; i++) begin
      dreq(1, 32'h2000, 32'(i));
      step();
    end
    dreq(0, 32'h2008, 0);
    #1 chk("outq_full_status", dmemresp_rdata, 0);
    chk("outq_ovf_err", 32'(err), 1);
    chk("outq_val", 32'(out_val), 1);
    idle();
    out_rdy = 1;
    for (int i = 1; i <= 4; i++) begin
      #1 chk($sformatf("outq_data%0d", i), out_data, 32'(i));
      step();
    end
    chk("outq_drained", 32'(out_val), 0);
    out_rdy = 0;
    do_reset();
    #1 chk("reset_clears_err", 32'(err), 0);
    in_val = 1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_val = 0;
    dreq(0, 32'h2008, 0);
    #1 chk("inq_status", dmemresp_rdata, 3);
    dreq(0, 32'h2004, 0);
    #1 chk("inq_rd_a", dmemresp_rdata, 32'hA);
    step();
    chk("inq_rd_b", dmemresp_rdata, 32'hB);
    step();
    chk("inq_rd_empty", dmemresp_rdata, 0);
    chk("inq_err_before", 32'(err), 0);
    step();
    idle();
    #1 chk("inq_unf_err", 32'(err), 1);
    do_reset();
    for (int i = 10; i <= 13; i++) begin
      dreq(1, 32'h2000, 32'(i));
      step();
    end
    out_rdy = 1;
    for (int i = 14; i <= 15; i++) begin
      dreq(1, 32'h2000, 32'(i));
      #1 chk($sformatf("pp_head%0d", i), out_data, 32'(i - 4));
      step();
    end
    dreq(0, 32'h2008, 0);
    #1 chk("pp_still_full", dmemresp_rdata, 0);
    idle();
    for (int i = 12; i <= 15; i++) begin
      #1 chk($sformatf("pp_drain%0d", i), out_data, 32'(i));
      step();
    end
    chk("pp_empty", 32'(out_val), 0);
    chk("pp_err", 32'(err), 0);
    out_rdy = 0;
    dreq(0, 32'h3, 0);
    #1 chk("bad_addr_rdata", dmemresp_rdata, 0);
    step();
    chk("bad_addr_err", 32'(err), 1);
    in_val = 1; in_data = 32'h5;
    dreq(1, 32'h2000, 32'h7);
    step();
    chk("pre_rst_out_val", 32'(out_val), 1);
    rst = 1;
    dreq(1, 32'h20, 32'h99);
    step();
    rst = 0;
    idle();
    imemreq_val = 1; imemreq_addr = 32'h10;
    dreq(0, 32'h20, 0);
    #1 chk("mid_rst_out_val", 32'(out_val), 0);
    chk("mid_rst_in_rdy", 32'(in_rdy), 1);
    chk("mid_rst_err", 32'(err), 0);
    chk("ram_persist", imemresp_data, 32'hDEAD_BEEF);
    chk("rst_write_ignored", dmemresp_rdata, 32'h1234_5678);
    dreq(0, 32'h2008, 0);
    #1 chk("mid_rst_status", dmemresp_rdata, 1);
    step();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
